// File: rtl/mima_pkg.sv
// mima_pkg: shared fetch-stage types and constants
package mima_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        misalign;
  } fetch_entry_t;
  typedef enum logic {FETCH, HALT} ifetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; flush beats push beats nothing
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  T     din_i,
  output logic full_o,
  output logic empty_o,
  output T     head_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/ifetch.sv
// ifetch: PC owner and fetch buffer feeding decode over valid/ready, flushed on redirect
module ifetch
  import mima_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_misalign
);
  ifetch_state_e state_q, state_d;
  logic [31:0]   pc_q, pc_d, mpc_q, mpc_d;
  logic          mark_q, mark_d;
  logic          full, empty, push, pop, deq, aligned;
  fetch_entry_t  head, hd;
  assign imem_addr = pc_q;
  assign aligned   = redirect_pc[1:0] == 2'b00;
  // A misaligned redirect parks its marker outside the FIFO; HALT keeps the FIFO empty meanwhile
  assign if_valid  = !empty || mark_q;
  assign hd        = mark_q ? fetch_entry_t'{pc: mpc_q, inst: NOP_INST, misalign: 1'b1} : head;
  assign {if_pc, if_inst, if_misalign} = if_valid ? hd : '0;
  assign deq  = if_valid && if_ready;
  assign push = (state_q == FETCH) && !redirect_valid && (!full || deq);
  assign pop  = deq && !mark_q;
  always_comb begin
    pc_d    = redirect_valid ? (aligned ? redirect_pc : pc_q) : (push ? pc_q + 32'd4 : pc_q);
    state_d = redirect_valid ? (aligned ? FETCH : HALT) : state_q;
    mark_d  = redirect_valid ? !aligned : (mark_q && !deq);
    mpc_d   = redirect_valid ? redirect_pc : mpc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      mark_q  <= 1'b0;
      mpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mark_q  <= mark_d;
      mpc_q   <= mpc_d;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect_valid),
    .din_i  (fetch_entry_t'{pc: pc_q, inst: imem_rdata, misalign: 1'b0}),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: table-driven cycle-by-cycle check of ifetch plus redirect latency sequences
module tb_ifetch;
  import mima_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_pc, if_inst;
  logic        redirect_valid, if_valid, if_ready, if_misalign;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hDEAD_0000 | {16'h0000, a[15:0]};
  endfunction
  assign imem_rdata = mem(imem_addr);
  ifetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_misalign   (if_misalign)
  );
  typedef struct {
    logic        ev;
    logic [31:0] epc;
    logic        emis;
    logic [31:0] eaddr;
    logic        r;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
  } vec_t;
  vec_t tv[28];
  function automatic vec_t mk(input logic ev, input logic [31:0] epc, input logic emis,
                              input logic [31:0] eaddr, input logic r, input logic rdy,
                              input logic rv, input logic [31:0] rpc);
    vec_t v;
    v.ev = ev; v.epc = epc; v.emis = emis; v.eaddr = eaddr;
    v.r = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    return v;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] ei;
    int n;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    tv[0]  = mk(0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0);
    tv[1]  = mk(1, 32'h0,        0, 32'h4,        0, 1, 0, 32'h0);
    tv[2]  = mk(1, 32'h4,        0, 32'h8,        0, 1, 0, 32'h0);
    tv[3]  = mk(1, 32'h8,        0, 32'hC,        0, 1, 0, 32'h0);
    tv[4]  = mk(1, 32'hC,        0, 32'h10,       0, 0, 0, 32'h0);
    tv[5]  = mk(1, 32'hC,        0, 32'h14,       0, 0, 0, 32'h0);
    tv[6]  = mk(1, 32'hC,        0, 32'h14,       0, 0, 0, 32'h0);
    tv[7]  = mk(1, 32'hC,        0, 32'h14,       0, 0, 0, 32'h0);
    tv[8]  = mk(1, 32'hC,        0, 32'h14,       0, 1, 0, 32'h0);
    tv[9]  = mk(1, 32'h10,       0, 32'h18,       0, 1, 0, 32'h0);
    tv[10] = mk(1, 32'h14,       0, 32'h1C,       0, 0, 1, 32'h100);
    tv[11] = mk(0, 32'h0,        0, 32'h100,      0, 1, 0, 32'h0);
    tv[12] = mk(1, 32'h100,      0, 32'h104,      0, 1, 0, 32'h0);
    tv[13] = mk(1, 32'h104,      0, 32'h108,      0, 0, 0, 32'h0);
    tv[14] = mk(1, 32'h104,      0, 32'h10C,      0, 1, 1, 32'h102);
    tv[15] = mk(1, 32'h102,      1, 32'h10C,      0, 0, 0, 32'h0);
    tv[16] = mk(1, 32'h102,      1, 32'h10C,      0, 1, 0, 32'h0);
    tv[17] = mk(0, 32'h0,        0, 32'h10C,      0, 1, 0, 32'h0);
    tv[18] = mk(0, 32'h0,        0, 32'h10C,      0, 1, 1, 32'h200);
    tv[19] = mk(0, 32'h0,        0, 32'h200,      0, 1, 0, 32'h0);
    tv[20] = mk(1, 32'h200,      0, 32'h204,      0, 0, 0, 32'h0);
    tv[21] = mk(1, 32'h200,      0, 32'h208,      1, 1, 1, 32'h300);
    tv[22] = mk(0, 32'h0,        0, 32'h0,        0, 1, 0, 32'h0);
    tv[23] = mk(1, 32'h0,        0, 32'h4,        0, 1, 0, 32'h0);
    tv[24] = mk(1, 32'h4,        0, 32'h8,        0, 1, 1, 32'hFFFF_FFFC);
    tv[25] = mk(0, 32'h0,        0, 32'hFFFF_FFFC, 0, 1, 0, 32'h0);
    tv[26] = mk(1, 32'hFFFF_FFFC, 0, 32'h0,       0, 1, 0, 32'h0);
    tv[27] = mk(1, 32'h0,        0, 32'h4,        0, 1, 0, 32'h0);
    for (int i = 0; i < 28; i++) begin
      ei = !tv[i].ev ? 32'h0 : (tv[i].emis ? NOP_INST : mem(tv[i].epc));
      chk($sformatf("r%0d_valid", i), {31'b0, if_valid}, {31'b0, tv[i].ev});
      chk($sformatf("r%0d_addr", i), imem_addr, tv[i].eaddr);
      chk($sformatf("r%0d_pc", i), if_pc, tv[i].epc);
      chk($sformatf("r%0d_inst", i), if_inst, ei);
      chk($sformatf("r%0d_mis", i), {31'b0, if_misalign}, {31'b0, tv[i].emis});
      rst = tv[i].r;
      if_ready = tv[i].rdy;
      redirect_valid = tv[i].rv;
      redirect_pc = tv[i].rpc;
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    n = 1;
    while (!if_valid && n < 6) begin
      tick();
      n++;
    end
    chk("aligned_latency", n, 2);
    chk("aligned_pc", if_pc, 32'h400);
    chk("aligned_inst", if_inst, mem(32'h400));
    redirect_valid = 1'b1;
    redirect_pc = 32'h403;
    tick();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    n = 1;
    while (!if_valid && n < 6) begin
      tick();
      n++;
    end
    chk("misalign_latency", n, 1);
    chk("misalign_pc", if_pc, 32'h403);
    chk("misalign_inst", if_inst, NOP_INST);
    chk("misalign_flag", {31'b0, if_misalign}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
